// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave between the inst and data masters,
// with fixed data priority, a request lock and an in-order owner FIFO for responses.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  logic [OUTSTANDING-1:0] r_fifo;
  logic [PW-1:0]          r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_lock, r_lock_owner;
  logic                   w_owner, w_req, w_pop, w_room, w_push, w_head;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    w_owner           = r_lock ? r_lock_owner : data_sram_req;
    w_req             = w_owner ? data_sram_req : inst_sram_req;
    w_pop             = resetn & mem_data_ok & (|r_count);
    w_room            = (r_count < CW'(OUTSTANDING)) | w_pop;
    mem_req           = resetn & w_req & w_room;
    w_push            = mem_req & mem_addr_ok;
    mem_wr            = w_owner ? data_sram_wr    : inst_sram_wr;
    mem_size          = w_owner ? data_sram_size  : inst_sram_size;
    mem_wstrb         = w_owner ? data_sram_wstrb : inst_sram_wstrb;
    mem_addr          = w_owner ? data_sram_addr  : inst_sram_addr;
    mem_wdata         = w_owner ? data_sram_wdata : inst_sram_wdata;
    inst_sram_addr_ok = w_push & ~w_owner;
    data_sram_addr_ok = w_push & w_owner;
    w_head            = r_fifo[r_rd_ptr];
    inst_sram_data_ok = w_pop & ~w_head;
    data_sram_data_ok = w_pop & w_head;
    inst_sram_rdata   = mem_rdata;
    data_sram_rdata   = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fifo       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_lock       <= 1'b0;
      r_lock_owner <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_owner;
        r_wr_ptr         <= nxt(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= nxt(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_lock <= 1'b0;
      else if (mem_req & ~mem_addr_ok) begin
        r_lock       <= 1'b1;
        r_lock_owner <= w_owner;
      end
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: vector table for grants plus an owner scoreboard for responses.
module tb_sram_like_arbiter;
  logic clk = 1'b0, resetn = 1'b0;
  logic ireq, iwr, dreq, dwr, maok, mdok;
  logic [1:0] isize, dsize, msize;
  logic [3:0] iwstrb, dwstrb, mwstrb;
  logic [31:0] iaddr, iwdata, daddr, dwdata, mrdata;
  logic iaok, idok, daok, ddok, mreq, mwr;
  logic [31:0] irdata, drdata, maddr, mwdata;
  int n_checks = 0, n_errors = 0;
  logic sb[$];
  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(ireq), .inst_sram_wr(iwr), .inst_sram_size(isize), .inst_sram_wstrb(iwstrb),
    .inst_sram_addr(iaddr), .inst_sram_wdata(iwdata), .inst_sram_addr_ok(iaok),
    .inst_sram_data_ok(idok), .inst_sram_rdata(irdata),
    .data_sram_req(dreq), .data_sram_wr(dwr), .data_sram_size(dsize), .data_sram_wstrb(dwstrb),
    .data_sram_addr(daddr), .data_sram_wdata(dwdata), .data_sram_addr_ok(daok),
    .data_sram_data_ok(ddok), .data_sram_rdata(drdata),
    .mem_req(mreq), .mem_wr(mwr), .mem_size(msize), .mem_wstrb(mwstrb), .mem_addr(maddr),
    .mem_wdata(mwdata), .mem_addr_ok(maok), .mem_data_ok(mdok), .mem_rdata(mrdata)
  );

  typedef struct packed {
    logic ireq; logic [31:0] iaddr; logic dreq; logic dwr; logic [31:0] daddr;
    logic maok; logic mdok; logic [31:0] rdata;
    logic e_mreq; logic [31:0] e_maddr; logic e_mwr; logic e_iaok; logic e_daok;
  } vec_t;

  function automatic vec_t mk(logic a, logic [31:0] b, logic c, logic d, logic [31:0] e,
                              logic f, logic g, logic [31:0] h, logic i, logic [31:0] j,
                              logic k, logic l, logic m);
    return '{a, b, c, d, e, f, g, h, i, j, k, l, m};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    logic own;
    @(negedge clk);
    ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwr = v.dwr; daddr = v.daddr;
    maok = v.maok; mdok = v.mdok; mrdata = v.rdata;
    #2;
    chk($sformatf("v%0d mem_req", idx), 32'(mreq), 32'(v.e_mreq));
    if (v.e_mreq) begin
      chk($sformatf("v%0d mem_addr", idx), maddr, v.e_maddr);
      chk($sformatf("v%0d mem_wr", idx), 32'(mwr), 32'(v.e_mwr));
    end
    chk($sformatf("v%0d inst_addr_ok", idx), 32'(iaok), 32'(v.e_iaok));
    chk($sformatf("v%0d data_addr_ok", idx), 32'(daok), 32'(v.e_daok));
    if (v.mdok && sb.size() > 0) begin
      own = sb.pop_front();
      chk($sformatf("v%0d inst_data_ok", idx), 32'(idok), 32'(!own));
      chk($sformatf("v%0d data_data_ok", idx), 32'(ddok), 32'(own));
      chk($sformatf("v%0d rdata", idx), own ? drdata : irdata, v.rdata);
    end else begin
      chk($sformatf("v%0d inst_data_ok idle", idx), 32'(idok), 32'd0);
      chk($sformatf("v%0d data_data_ok idle", idx), 32'(ddok), 32'd0);
    end
    if (v.e_iaok) sb.push_back(1'b0);
    if (v.e_daok) sb.push_back(1'b1);
  endtask

  localparam logic [31:0] IA = 32'hBFC00000, DA = 32'h80001000;
  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1, IA,    0, 0, 0,    1, 0, 0,            1, IA,    0, 1, 0);
    tbl[1]  = mk(0, IA,    0, 0, 0,    0, 0, 0,            0, 0,     0, 0, 0);
    tbl[2]  = mk(0, IA,    0, 0, 0,    0, 1, 32'h3C080001, 0, 0,     0, 0, 0);
    tbl[3]  = mk(1, IA+4,  1, 1, DA,   1, 0, 0,            1, DA,    1, 0, 1);
    tbl[4]  = mk(1, IA+4,  0, 0, 0,    1, 0, 0,            1, IA+4,  0, 1, 0);
    tbl[5]  = mk(0, IA,    0, 0, 0,    0, 1, 32'h11111111, 0, 0,     0, 0, 0);
    tbl[6]  = mk(0, IA,    0, 0, 0,    0, 1, 32'h22222222, 0, 0,     0, 0, 0);
    tbl[7]  = mk(1, IA+8,  0, 0, 0,    0, 0, 0,            1, IA+8,  0, 0, 0);
    tbl[8]  = mk(1, IA+8,  0, 0, 0,    0, 0, 0,            1, IA+8,  0, 0, 0);
    tbl[9]  = mk(1, IA+8,  0, 0, 0,    0, 0, 0,            1, IA+8,  0, 0, 0);
    tbl[10] = mk(1, IA+8,  1, 0, DA+4, 0, 0, 0,            1, IA+8,  0, 0, 0);
    tbl[11] = mk(1, IA+8,  1, 0, DA+4, 1, 0, 0,            1, IA+8,  0, 1, 0);
    tbl[12] = mk(0, IA+8,  1, 0, DA+4, 1, 0, 0,            1, DA+4,  0, 0, 1);
    tbl[13] = mk(1, IA+12, 0, 0, 0,    1, 0, 0,            0, 0,     0, 0, 0);
    tbl[14] = mk(1, IA+12, 0, 0, 0,    1, 1, 32'h33333333, 1, IA+12, 0, 1, 0);
    tbl[15] = mk(0, IA,    0, 0, 0,    0, 1, 32'h44444444, 0, 0,     0, 0, 0);
    tbl[16] = mk(0, IA,    0, 0, 0,    0, 1, 32'h55555555, 0, 0,     0, 0, 0);
    tbl[17] = mk(0, IA,    0, 0, 0,    0, 1, 32'h66666666, 0, 0,     0, 0, 0);
    tbl[18] = mk(1, IA,    0, 0, 0,    1, 0, 0,            1, IA,    0, 1, 0);
    tbl[19] = mk(0, IA,    0, 0, 0,    0, 1, 32'h77777777, 0, 0,     0, 0, 0);
    iwr = 0; isize = 2'd2; iwstrb = 4'h0; iwdata = 0;
    dsize = 2'd2; dwstrb = 4'hF; dwdata = 32'h12345678;
    ireq = 1; dreq = 1; dwr = 0; iaddr = IA; daddr = DA; maok = 1; mdok = 1; mrdata = 0;
    @(negedge clk);
    #2;
    chk("reset mem_req", 32'(mreq), 0);
    chk("reset inst_addr_ok", 32'(iaok), 0);
    chk("reset data_addr_ok", 32'(daok), 0);
    chk("reset inst_data_ok", 32'(idok), 0);
    chk("reset data_data_ok", 32'(ddok), 0);
    @(negedge clk);
    resetn = 1; ireq = 0; dreq = 0; maok = 0; mdok = 0;
    for (int i = 0; i < 20; i++) apply(tbl[i], i);
    apply(mk(0, IA, 1, 0, DA, 1, 0, 0, 1, DA, 0, 0, 1), 20);
    @(negedge clk);
    resetn = 0; dreq = 1; maok = 1; mdok = 1;
    #2;
    chk("midreset mem_req", 32'(mreq), 0);
    chk("midreset data_addr_ok", 32'(daok), 0);
    chk("midreset data_data_ok", 32'(ddok), 0);
    sb.delete();
    @(negedge clk);
    resetn = 1; dreq = 0; maok = 0; mdok = 0;
    apply(mk(0, IA, 0, 0, 0, 0, 1, 32'h88888888, 0, 0, 0, 0, 0), 21);
    apply(mk(1, IA, 0, 0, 0, 1, 0, 0, 1, IA, 0, 1, 0), 22);
    apply(mk(0, IA, 0, 0, 0, 0, 1, 32'h99999999, 0, 0, 0, 0, 0), 23);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
